sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM-facing Avalon-MM master port between two requester engines, e.g. the word-copy engine on port 0 and the accelerator datapath on port 1.
- Each requester sees a slave-side Avalon interface with waitrequest and pipelined reads.
- Arbitration is round-robin, one transaction per grant.
- Outstanding reads are tracked in an ID FIFO, so readdatavalid is routed back to the requester that issued the read.

Parameters:
- MAX_OUTSTANDING, 8: depth of the read-ID FIFO, i.e. the maximum number of reads in flight at the SDRAM. Must be a power of two, 2 to 64.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- r0_waitrequest  out  1  stall for requester 0
- r0_address  in  32  requester 0 address
- r0_read  in  1  requester 0 read request
- r0_write  in  1  requester 0 write request
- r0_writedata  in  32  requester 0 write data
- r0_readdata  out  32  read data returned to requester 0
- r0_readdatavalid  out  1  read data valid for requester 0
- r1_*  same seven ports as r0_*  requester 1
- master_waitrequest  in  1  SDRAM stall
- master_address  out  32  SDRAM address
- master_read  out  1  SDRAM read
- master_write  out  1  SDRAM write
- master_writedata  out  32  SDRAM write data
- master_readdata  in  32  SDRAM read data
- master_readdatavalid  in  1  SDRAM read data valid
- err  out  1  sticky protocol error; see Optional Feature

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, prio=0, FIFO emptied, err=0.
  - master_read/master_write=0, master_address/master_writedata=0.
  - rX_waitrequest=1, rX_readdatavalid=0.
- Data return:
  - rX_readdata = master_readdata for both requesters, combinational.
  - Only the routed readdatavalid marks the data as valid.
- A request from X is "req_X" = rX_read|rX_write.
- A read is "eligible" only if the FIFO is not full. Writes are always eligible.
- Both requesters hold address, data and command stable while their waitrequest=1; the arbiter relies on this.
- State machine, states IDLE, OWN0, OWN1:
  - IDLE:
    - Grant to eligible req_prio if present, else to the other eligible requester, else stay.
    - Next state is OWN0 or OWN1. Grant latency is 1 cycle; no master command is driven in IDLE.
  - OWNx, master side:
    - master_* = rX_* combinationally.
    - rX_waitrequest = master_waitrequest; the other requester's waitrequest = 1.
  - OWNx, acceptance = (master_read|master_write) & ~master_waitrequest. On acceptance:
    - next state is IDLE and prio becomes 1-x.
    - If master_read was accepted, push x into the FIFO.
  - OWNx, request dropped: if rX_read and rX_write both fall while in OWNx (protocol abuse), go to IDLE with no push.
- A single grant covers exactly one command. There is no bursting and no grant locking across commands.
- FIFO:
  - On master_readdatavalid, pop the head ID h and assert rh_readdatavalid=1 for that cycle only. The other requester's readdatavalid stays 0.
  - Push and pop in the same cycle: occupancy unchanged, both operations take effect.
  - FIFO full: a pending read from the owner is not granted and the arbiter stays in IDLE. A write from the other requester may be granted meanwhile.
  - FIFO empty when master_readdatavalid=1: the data is dropped and neither readdatavalid asserts.
- rX_read and rX_write both high is illegal. If it occurs, forward both unchanged.
- Reset mid-operation clears the FIFO. Any read data arriving after reset is dropped as an empty-FIFO return.
- Throughput: at most one accepted command every 2 cycles. Read-return order equals issue order, per Avalon pipelined reads.

Optional Feature:
- Macro: SDRAM_ARBITER_ERR_EN.
- Defined: err is set, and stays set until reset, on either event:
  - master_readdatavalid while the FIFO is empty, with no push that cycle;
  - an OWNx request dropped before acceptance.
- Not defined: err is tied to 0 and no error logic is synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then r0 write addr 0x100 data 0xA5A5A5A5 with master_waitrequest=0 -> master_write=1, master_address=0x100 in cycle 2; r0_waitrequest low in that cycle; state returns to IDLE.
- r0 and r1 both request writes continuously, master_waitrequest=0 -> accepted order r0,r1,r0,r1, one accept every 2 cycles.
- r1 read 0x200 accepted; master_waitrequest held high 3 cycles first -> r1_waitrequest=1 for those 3 cycles; later master_readdatavalid with 0xDEADBEEF -> r1_readdatavalid=1, r0_readdatavalid=0.
- Interleaved reads r0,r1,r0 with returns delayed 5 cycles, one return coinciding with a new push -> valids routed r0,r1,r0; FIFO count stays correct.
- MAX_OUTSTANDING=2 with no returns -> the third read stalls in IDLE while an r1 write is still granted; after one return the read is granted.
- SDRAM_ARBITER_ERR_EN defined: master_readdatavalid with the FIFO empty -> err=1 until rst_n pulses low; not defined -> err stays 0.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM master between two requesters.
// Optional sticky protocol-error flag enabled by defining SDRAM_ARBITER_ERR_EN.
module sdram_arbiter #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        r0_waitrequest,
    input  logic [31:0] r0_address,
    input  logic        r0_read,
    input  logic        r0_write,
    input  logic [31:0] r0_writedata,
    output logic [31:0] r0_readdata,
    output logic        r0_readdatavalid,
    output logic        r1_waitrequest,
    input  logic [31:0] r1_address,
    input  logic        r1_read,
    input  logic        r1_write,
    input  logic [31:0] r1_writedata,
    output logic [31:0] r1_readdata,
    output logic        r1_readdatavalid,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        err
);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e          state_q;
    logic            prio_q;
    logic            ids_q [MAX_OUTSTANDING];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;

    logic full, empty, elig0, elig1, accept, push, pop, head, owner_req, drop;

    assign full  = (count_q == (AW+1)'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    // A write never needs a FIFO slot, so only reads are held back when full.
    assign elig0 = r0_write | (r0_read & ~full);
    assign elig1 = r1_write | (r1_read & ~full);

    always_comb begin
        master_address   = '0;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_writedata = '0;
        r0_waitrequest   = 1'b1;
        r1_waitrequest   = 1'b1;
        owner_req        = 1'b0;
        case (state_q)
            OWN0: begin
                master_address   = r0_address;
                master_read      = r0_read;
                master_write     = r0_write;
                master_writedata = r0_writedata;
                r0_waitrequest   = master_waitrequest;
                owner_req        = r0_read | r0_write;
            end
            OWN1: begin
                master_address   = r1_address;
                master_read      = r1_read;
                master_write     = r1_write;
                master_writedata = r1_writedata;
                r1_waitrequest   = master_waitrequest;
                owner_req        = r1_read | r1_write;
            end
            default: ;
        endcase
    end

    assign accept = (master_read | master_write) & ~master_waitrequest;
    assign push   = accept & master_read;
    assign pop    = master_readdatavalid & ~empty;
    assign head   = ids_q[rd_ptr_q];
    assign drop   = (state_q != IDLE) & ~owner_req;

    assign r0_readdata      = master_readdata;
    assign r1_readdata      = master_readdata;
    assign r0_readdatavalid = pop & ~head;
    assign r1_readdatavalid = pop & head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!prio_q) begin
                        if (elig0)      state_q <= OWN0;
                        else if (elig1) state_q <= OWN1;
                    end else begin
                        if (elig1)      state_q <= OWN1;
                        else if (elig0) state_q <= OWN0;
                    end
                end
                OWN0: begin
                    if (accept) begin
                        state_q <= IDLE;
                        prio_q  <= 1'b1;
                    end else if (drop) begin
                        state_q <= IDLE;
                    end
                end
                OWN1: begin
                    if (accept) begin
                        state_q <= IDLE;
                        prio_q  <= 1'b0;
                    end else if (drop) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ID storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) ids_q[wr_ptr_q] <= (state_q == OWN1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef SDRAM_ARBITER_ERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((master_readdatavalid & empty & ~push) | drop) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a default-depth instance and a depth-2 instance
// share the same stimulus; each step checks hand-computed expectations.
module tb_sdram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] r0_address = '0, r1_address = '0, r0_writedata = '0, r1_writedata = '0;
    logic        r0_read = 1'b0, r0_write = 1'b0, r1_read = 1'b0, r1_write = 1'b0;
    logic        m_wait = 1'b0, m_rdv = 1'b0;
    logic [31:0] m_rdata = '0;

    logic        a_r0_wait, a_r1_wait, a_r0_rdv, a_r1_rdv, a_m_read, a_m_write, a_err;
    logic [31:0] a_r0_rdata, a_r1_rdata, a_m_addr, a_m_wdata;
    logic        b_r0_wait, b_r1_wait, b_r0_rdv, b_r1_rdv, b_m_read, b_m_write, b_err;
    logic [31:0] b_r0_rdata, b_r1_rdata, b_m_addr, b_m_wdata;

    int checks = 0;
    int errors = 0;

`ifdef SDRAM_ARBITER_ERR_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    always #5 clk = ~clk;

    sdram_arbiter u_a (
        .clk(clk), .rst_n(rst_n),
        .r0_waitrequest(a_r0_wait), .r0_address(r0_address), .r0_read(r0_read),
        .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_readdata(a_r0_rdata),
        .r0_readdatavalid(a_r0_rdv),
        .r1_waitrequest(a_r1_wait), .r1_address(r1_address), .r1_read(r1_read),
        .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_readdata(a_r1_rdata),
        .r1_readdatavalid(a_r1_rdv),
        .master_waitrequest(m_wait), .master_address(a_m_addr), .master_read(a_m_read),
        .master_write(a_m_write), .master_writedata(a_m_wdata), .master_readdata(m_rdata),
        .master_readdatavalid(m_rdv), .err(a_err)
    );

    sdram_arbiter #(.MAX_OUTSTANDING(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .r0_waitrequest(b_r0_wait), .r0_address(r0_address), .r0_read(r0_read),
        .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_readdata(b_r0_rdata),
        .r0_readdatavalid(b_r0_rdv),
        .r1_waitrequest(b_r1_wait), .r1_address(r1_address), .r1_read(r1_read),
        .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_readdata(b_r1_rdata),
        .r1_readdatavalid(b_r1_rdv),
        .master_waitrequest(m_wait), .master_address(b_m_addr), .master_read(b_m_read),
        .master_write(b_m_write), .master_writedata(b_m_wdata), .master_readdata(m_rdata),
        .master_readdatavalid(m_rdv), .err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
        m_wait = 0; m_rdv = 0;
    endtask

    task automatic rst_pulse();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_addr [8];
    logic [31:0] exp_wr   [8];

    initial begin
        // Reset values
        #2;
        chk("rst_r0_wait", 32'(a_r0_wait), 32'd1);
        chk("rst_r1_wait", 32'(a_r1_wait), 32'd1);
        chk("rst_m_read",  32'(a_m_read),  32'd0);
        chk("rst_m_write", 32'(a_m_write), 32'd0);
        chk("rst_m_addr",  a_m_addr,       32'd0);
        chk("rst_m_wdata", a_m_wdata,      32'd0);
        chk("rst_rdv",     32'({a_r0_rdv, a_r1_rdv}), 32'd0);
        chk("rst_err",     32'(a_err),     32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single r0 write, one-cycle grant latency
        r0_write = 1; r0_address = 32'h100; r0_writedata = 32'hA5A5A5A5; #1;
        chk("w1_idle_m_write", 32'(a_m_write), 32'd0);
        chk("w1_idle_r0_wait", 32'(a_r0_wait), 32'd1);
        tick();
        chk("w1_m_write", 32'(a_m_write), 32'd1);
        chk("w1_m_addr",  a_m_addr, 32'h100);
        chk("w1_m_wdata", a_m_wdata, 32'hA5A5A5A5);
        chk("w1_r0_wait", 32'(a_r0_wait), 32'd0);
        chk("w1_r1_wait", 32'(a_r1_wait), 32'd1);
        tick();
        r0_write = 0; #1;
        chk("w1_back_idle", 32'(a_m_write), 32'd0);
        chk("w1_back_wait", 32'(a_r0_wait), 32'd1);

        // Both requesters write continuously: r0,r1,r0,r1, one accept per 2 cycles
        rst_pulse();
        exp_wr   = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
        exp_addr = '{32'h0, 32'h10, 32'h0, 32'h20, 32'h0, 32'h10, 32'h0, 32'h20};
        r0_write = 1; r0_address = 32'h10; r0_writedata = 32'h1111;
        r1_write = 1; r1_address = 32'h20; r1_writedata = 32'h2222;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_write_%0d", i), 32'(a_m_write), exp_wr[i]);
            chk($sformatf("rr_addr_%0d", i),  a_m_addr, exp_addr[i]);
            tick();
        end
        r0_write = 0; r1_write = 0;
        tick();

        // r1 read stalled 3 cycles by the SDRAM, then data routed back to r1
        r1_read = 1; r1_address = 32'h200; m_wait = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rd_stall_r1_wait_%0d", i), 32'(a_r1_wait), 32'd1);
            chk($sformatf("rd_stall_m_read_%0d", i),  32'(a_m_read), 32'd1);
            tick();
        end
        m_wait = 0; #1;
        chk("rd_r1_wait_low", 32'(a_r1_wait), 32'd0);
        chk("rd_m_addr", a_m_addr, 32'h200);
        tick();
        r1_read = 0;
        tick();
        m_rdv = 1; m_rdata = 32'hDEADBEEF; #1;
        chk("rd_r1_rdv",   32'(a_r1_rdv), 32'd1);
        chk("rd_r0_rdv",   32'(a_r0_rdv), 32'd0);
        chk("rd_r1_rdata", a_r1_rdata, 32'hDEADBEEF);
        tick();
        m_rdv = 0; #1;
        chk("rd_r1_rdv_one_cycle", 32'(a_r1_rdv), 32'd0);

        // Interleaved reads r0,r1,r0; first return coincides with the third push
        tick();
        r0_read = 1; r0_address = 32'h300;
        tick();
        chk("il_addr0", a_m_addr, 32'h300);
        tick();
        r0_read = 0; r1_read = 1; r1_address = 32'h304;
        tick();
        chk("il_addr1", a_m_addr, 32'h304);
        tick();
        r1_read = 0; r0_read = 1; r0_address = 32'h308;
        tick();
        m_rdv = 1; m_rdata = 32'h11; #1;
        chk("il_addr2",  a_m_addr, 32'h308);
        chk("il_ret0_r0", 32'(a_r0_rdv), 32'd1);
        chk("il_ret0_r1", 32'(a_r1_rdv), 32'd0);
        tick();
        r0_read = 0; m_rdv = 0; #1;
        chk("il_gap", 32'({a_r0_rdv, a_r1_rdv}), 32'd0);
        tick();
        m_rdv = 1; #1;
        chk("il_ret1_r1", 32'(a_r1_rdv), 32'd1);
        chk("il_ret1_r0", 32'(a_r0_rdv), 32'd0);
        tick();
        #1;
        chk("il_ret2_r0", 32'(a_r0_rdv), 32'd1);
        chk("il_ret2_r1", 32'(a_r1_rdv), 32'd0);
        tick();
        #1;
        chk("il_empty_drop", 32'({a_r0_rdv, a_r1_rdv}), 32'd0);
        tick();
        m_rdv = 0; #1;
        chk("err_after_empty_return", 32'(a_err), EXP_ERR);
        tick();
        chk("err_still_set", 32'(a_err), EXP_ERR);
        rst_pulse();
        #1;
        chk("err_cleared_by_reset", 32'(a_err), 32'd0);

        // Depth-2 instance: third read stalls while an r1 write still gets through
        tick();
        r0_read = 1; r0_address = 32'h400; #1;
        chk("full_t0", 32'(b_m_read), 32'd0);
        tick();
        chk("full_t1", 32'(b_m_read), 32'd1);
        tick();
        chk("full_t2", 32'(b_m_read), 32'd0);
        tick();
        chk("full_t3", 32'(b_m_read), 32'd1);
        tick();
        r1_write = 1; r1_address = 32'h500; r1_writedata = 32'h55; #1;
        chk("full_t4_read",  32'(b_m_read), 32'd0);
        chk("full_t4_write", 32'(b_m_write), 32'd0);
        tick();
        chk("full_w_write", 32'(b_m_write), 32'd1);
        chk("full_w_addr",  b_m_addr, 32'h500);
        chk("full_w_r1wait", 32'(b_r1_wait), 32'd0);
        chk("full_w_r0wait", 32'(b_r0_wait), 32'd1);
        tick();
        r1_write = 0; #1;
        chk("full_t6_read", 32'(b_m_read), 32'd0);
        tick();
        m_rdv = 1; #1;
        chk("full_t7_read", 32'(b_m_read), 32'd0);
        chk("full_t7_rdv",  32'(b_r0_rdv), 32'd1);
        tick();
        m_rdv = 0; #1;
        chk("full_t8_read", 32'(b_m_read), 32'd0);
        tick();
        chk("full_t9_read", 32'(b_m_read), 32'd1);
        chk("full_t9_addr", b_m_addr, 32'h400);
        tick();
        r0_read = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
